sample_iterator: RTL and testbench

- Rasterizer stage directly upstream of the sample test; it is the producer side of the sample interface.
- Accepts one triangle plus its snapped bounding box per handshake.
- Walks the box on the subsample grid in row-major order (x fastest) and emits one sample location per cycle, together with that triangle's vertices and colour.
- Stalls upstream with an active-low halt while iterating.

---
 rtl/sample_iterator_pkg.sv | 22 ++
 rtl/sample_axis_stepper.sv | 55 +++++
 rtl/sample_iterator.sv | 86 ++++++++
 tb/tb_sample_iterator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sample_iterator_pkg.sv
// Shared raster definitions: iterator states, subsample step codes and the
// code-to-step mapping used by the sample iterator.
package sample_iterator_pkg;

  typedef enum logic {WAIT, TEST} iter_state_t;

  localparam logic [3:0] SUB_1X = 4'b1000;
  localparam logic [3:0] SUB_2X = 4'b0100;
  localparam logic [3:0] SUB_4X = 4'b0010;
  localparam logic [3:0] SUB_8X = 4'b0001;

  // Unrecognised codes fall back to one sample per pixel.
  function automatic logic [31:0] sub_step(input logic [3:0] code, input int unsigned radix);
    case (code)
      SUB_2X:  return 32'd1 << (radix - 1);
      SUB_4X:  return 32'd1 << (radix - 2);
      SUB_8X:  return 32'd1 << (radix - 3);
      default: return 32'd1 << radix;
    endcase
  endfunction

endpackage

// File: rtl/sample_axis_stepper.sv
// One axis of the box walk: current position plus bounds/step, with a
// registered flag telling whether the next step would pass the upper bound.
module sample_axis_stepper #(
  parameter int SIGFIG = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     adv,
  input  logic                     wrap,
  input  logic signed [SIGFIG-1:0] lo_in,
  input  logic signed [SIGFIG-1:0] hi_in,
  input  logic signed [SIGFIG-1:0] step_in,
  output logic signed [SIGFIG-1:0] val,
  output logic                     over
);

  logic signed [SIGFIG-1:0] lo, hi, step, nxt, base, stp, bound;
  logic signed [SIGFIG:0]   sum, peek, lim;
  logic                     over_nxt;

  // One extra bit keeps the sums from wrapping near the top of the range.
  always_comb begin
    sum   = $signed({val[SIGFIG-1], val}) + $signed({step[SIGFIG-1], step});
    nxt   = val;
    if (wrap)     nxt = lo;
    else if (adv) nxt = sum[SIGFIG-1:0];
    base  = load ? lo_in   : nxt;
    stp   = load ? step_in : step;
    bound = load ? hi_in   : hi;
    peek  = $signed({base[SIGFIG-1], base}) + $signed({stp[SIGFIG-1], stp});
    lim   = $signed({bound[SIGFIG-1], bound});
    over_nxt = peek > lim;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      val  <= '0;
      lo   <= '0;
      hi   <= '0;
      step <= '0;
      over <= 1'b0;
    end else if (load) begin
      val  <= lo_in;
      lo   <= lo_in;
      hi   <= hi_in;
      step <= step_in;
      over <= over_nxt;
    end else if (adv || wrap) begin
      val  <= nxt;
      over <= over_nxt;
    end
  end

endmodule

// File: rtl/sample_iterator.sv
// Walks a triangle's snapped bounding box on the subsample grid, one sample
// per cycle. Optional SAMPLE_ITER_PERF_CNT_EN adds a per-box sample counter.
module sample_iterator
  import sample_iterator_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R14S   [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R14U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R14S   [2][2],
  input  logic                     validTri_R14H,
  input  logic        [3:0]        subSample_R14U,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R16S   [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R16U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R16S [2],
  output logic                     validSamp_R16H
`ifdef SAMPLE_ITER_PERF_CNT_EN
  ,
  output logic        [31:0]       sampCount_R16U
`endif
);

  iter_state_t              state;
  logic                     accept, degen, run, last, x_over, y_over;
  logic signed [SIGFIG-1:0] step_val, x_val, y_val;

  assign halt_RnnnnL = rst && (state == WAIT);
  assign accept      = (state == WAIT) && validTri_R14H && halt_RnnnnL;
  assign degen       = (box_R14S[1][0] < box_R14S[0][0]) || (box_R14S[1][1] < box_R14S[0][1]);
  assign run         = (state == TEST);
  assign last        = run && x_over && y_over;
  assign step_val    = SIGFIG'(sub_step(subSample_R14U, RADIX));

  // x wraps to the left edge and y steps only when x has run off the row.
  sample_axis_stepper #(.SIGFIG(SIGFIG)) u_x (
    .clk(clk), .rst(rst), .load(accept),
    .adv(run && !x_over), .wrap(run && x_over && !y_over),
    .lo_in(box_R14S[0][0]), .hi_in(box_R14S[1][0]), .step_in(step_val),
    .val(x_val), .over(x_over)
  );

  sample_axis_stepper #(.SIGFIG(SIGFIG)) u_y (
    .clk(clk), .rst(rst), .load(accept),
    .adv(run && x_over && !y_over), .wrap(1'b0),
    .lo_in(box_R14S[0][1]), .hi_in(box_R14S[1][1]), .step_in(step_val),
    .val(y_val), .over(y_over)
  );

  assign sample_R16S[0] = x_val;
  assign sample_R16S[1] = y_val;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= WAIT;
      validSamp_R16H <= 1'b0;
      tri_R16S       <= '{default: '0};
      color_R16U     <= '{default: '0};
    end else if (accept) begin
      tri_R16S   <= tri_R14S;
      color_R16U <= color_R14U;
      // A degenerate box is swallowed without leaving WAIT.
      if (!degen) begin
        state          <= TEST;
        validSamp_R16H <= 1'b1;
      end
    end else if (last) begin
      state          <= WAIT;
      validSamp_R16H <= 1'b0;
    end
  end

`ifdef SAMPLE_ITER_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst || accept)                         sampCount_R16U <= '0;
    else if (validSamp_R16H && sampCount_R16U != '1) sampCount_R16U <= sampCount_R16U + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Bench for sample_iterator: table of boxes checked against a scoreboard of
// expected samples, plus hand sequences for reset and held-valid cases.
module tb_sample_iterator;

  localparam int SIGFIG = 24;

  logic                     clk, rst, validTri, halt, vs;
  logic signed [SIGFIG-1:0] tri_in  [3][3];
  logic        [SIGFIG-1:0] col_in  [3];
  logic signed [SIGFIG-1:0] box_in  [2][2];
  logic        [3:0]        code;
  logic signed [SIGFIG-1:0] tri_out [3][3];
  logic        [SIGFIG-1:0] col_out [3];
  logic signed [SIGFIG-1:0] samp    [2];
`ifdef SAMPLE_ITER_PERF_CNT_EN
  logic        [31:0]       cnt;
`endif

  sample_iterator dut (
    .clk(clk), .rst(rst), .tri_R14S(tri_in), .color_R14U(col_in), .box_R14S(box_in),
    .validTri_R14H(validTri), .subSample_R14U(code), .halt_RnnnnL(halt),
    .tri_R16S(tri_out), .color_R16U(col_out), .sample_R16S(samp), .validSamp_R16H(vs)
`ifdef SAMPLE_ITER_PERF_CNT_EN
    , .sampCount_R16U(cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int x; int y; int tag;} samp_t;
  typedef struct {int llx; int lly; int urx; int ury; logic [3:0] code; int nexp;} vec_t;

  samp_t q[$];
  int    n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int step_of(input logic [3:0] c);
    case (c)
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  task automatic push_box(input vec_t v, input int tag);
    int st;
    st = step_of(v.code);
    for (int y = v.lly; y <= v.ury; y += st)
      for (int x = v.llx; x <= v.urx; x += st)
        q.push_back('{x, y, tag});
  endtask

  task automatic drive(input vec_t v, input int tag);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) tri_in[i][j] = SIGFIG'(tag + i*3 + j);
      col_in[i] = SIGFIG'(tag + 100 + i);
    end
    box_in[0][0] = SIGFIG'(v.llx);
    box_in[0][1] = SIGFIG'(v.lly);
    box_in[1][0] = SIGFIG'(v.urx);
    box_in[1][1] = SIGFIG'(v.ury);
    code     = v.code;
    validTri = 1'b1;
  endtask

  // Counts halt-low cycles until halt returns high, bounded.
  task automatic wait_box(output int lo_cyc);
    lo_cyc = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (halt) return;
      lo_cyc++;
    end
    chk("wait_box_timeout", 1, 0);
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    int n;
    push_box(v, tag);
    drive(v, tag);
    @(posedge clk); #1;
    validTri = 1'b0;
    wait_box(n);
    chk("halt_low_cycles", n, v.nexp);
    #1;
    chk("queue_drained", q.size(), 0);
`ifdef SAMPLE_ITER_PERF_CNT_EN
    chk("samp_count", cnt, v.nexp);
`endif
  endtask

  always @(negedge clk) begin
    samp_t e;
    if (vs) begin
      if (q.size() == 0) chk("extra_sample", 1, 0);
      else begin
        e = q.pop_front();
        chk("samp_x", samp[0], e.x);
        chk("samp_y", samp[1], e.y);
        chk("tri_held", tri_out[0][0], e.tag);
        chk("color_held", col_out[2], e.tag + 102);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  vec_t vt[7];
  vec_t b1, bpt, bpost;
  int   n;

  initial begin
    vt[0] = '{0, 0, 2048, 1024, 4'b1000, 6};
    vt[1] = '{5120, 3072, 5120, 3072, 4'b1000, 1};
    vt[2] = '{0, 0, 512, 0, 4'b0010, 3};
    vt[3] = '{0, 0, 512, 0, 4'b0110, 1};
    vt[4] = '{2048, 0, 1024, 0, 4'b1000, 0};
    vt[5] = '{-1024, -512, 0, 0, 4'b0100, 6};
    vt[6] = '{0, 0, 1500, 100, 4'b1000, 2};
    b1    = vt[0];
    bpt   = vt[1];
    bpost = '{1024, 2048, 2048, 2048, 4'b1000, 2};

    rst = 1'b0; validTri = 1'b0; code = 4'b1000;
    tri_in = '{default: '0}; col_in = '{default: '0}; box_in = '{default: '0};
    repeat (2) @(negedge clk);
    chk("rst_halt", halt, 0);
    chk("rst_valid", vs, 0);
    chk("rst_sample", samp[0], 0);
    chk("rst_tri", tri_out[2][2], 0);
    rst = 1'b1;
    @(negedge clk);
    chk("halt_after_rst", halt, 1);

    // Degenerate entry (4) is followed directly by entry 5: next-cycle accept.
    for (int i = 0; i < 7; i++) run_vec(vt[i], i*16 + 1);

    // Reset while the third sample is on the outputs.
    push_box(b1, 200);
    repeat (3) void'(q.pop_back());
    drive(b1, 200);
    @(posedge clk); #1;
    validTri = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", vs, 0);
    chk("midrst_sx", samp[0], 0);
    chk("midrst_sy", samp[1], 0);
    chk("midrst_tri", tri_out[0][0], 0);
    chk("midrst_halt", halt, 0);
    chk("midrst_queue", q.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_halt", halt, 1);
    run_vec(bpost, 300);

    // validTri held through box 1 with a new triangle: taken only in the bubble.
    push_box(b1, 400);
    push_box(bpt, 500);
    drive(b1, 400);
    @(posedge clk); #1;
    drive(bpt, 500);
    wait_box(n);
    chk("held_box1_cycles", n, 6);
`ifdef SAMPLE_ITER_PERF_CNT_EN
    chk("held_count_box1", cnt, 6);
`endif
    @(posedge clk); #1;
    validTri = 1'b0;
    wait_box(n);
    chk("held_box2_cycles", n, 1);
    #1;
    chk("held_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
